mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Consumer of the EX-stage output bundle (ex_stage_pkg::ex_stage_out_t); the memory stage of the core.
//  - Issues word loads/stores to data memory over a req/gnt/rvalid bus.
//  - Stalls EX while a memory access is outstanding.
//  - Delivers a registered writeback bundle to WB.
//  - Non-memory instructions pass through with 1-cycle latency.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles spent in REQ or WAIT before the access is aborted with bus_err
// PORTS
//  clk          in   1    core clock; all state on rising edge
//  rst          in   1    asynchronous, active-high reset
//  ex_in        in   $bits(ex_stage_out_t)  EX result: rd, opr_b (store data), opr_res (address/ALU result), rf_en, dm_en, wb_sel
//  ex_valid     in   1    ex_in holds a valid instruction
//  ex_ready     out  1    stage accepts ex_in this cycle (stall = !ex_ready)
//  dmem_req     out  1    memory request valid
//  dmem_we      out  1    1 = store, 0 = load
//  dmem_addr    out  32   word address {opr_res[31:2],2'b00}
//  dmem_wdata   out  32   store data (opr_b)
//  dmem_gnt     in   1    request accepted this cycle
//  dmem_rvalid  in   1    load data valid
//  dmem_rdata   in   32   load data
//  wb_out       out  $bits(mem_stage_out_t)  {rd, rf_en, wb_data[31:0], wb_sel}
//  wb_valid     out  1    wb_out valid for exactly one cycle per retired instruction
//  misalign     out  1    1-cycle pulse: memory op with opr_res[1:0]!=0 (no bus access made)
//  bus_err      out  1    1-cycle pulse: access aborted by timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including dmem_req, wb_valid, misalign, bus_err, wb_out.
//   ex_ready=1 in IDLE.
//  Classification of an accepted instruction (ex_valid && ex_ready):
//   - store: dm_en=1.
//   - load: dm_en=0 && wb_sel==WB_MEM.
//   - otherwise ALU/other.
//  FSM IDLE -> REQ -> WAIT -> IDLE:
//   IDLE:
//    - ALU/other: register wb_data=opr_res; wb_valid=1 next cycle; stay IDLE.
//    - Load/store, aligned: latch rd/rf_en/wb_sel/addr/wdata; go to REQ; ex_ready=0 from next cycle.
//    - Load/store, misaligned: no request; misalign pulse next cycle; wb_valid=1 with rf_en forced 0; stay IDLE.
//   REQ:
//    - dmem_req=1; addr/we/wdata held stable until gnt.
//    - On gnt: store -> IDLE, wb_valid=1 next cycle (rf_en as latched); load -> WAIT, req drops.
//   WAIT:
//    - On rvalid: wb_data=dmem_rdata; wb_valid=1 next cycle; go to IDLE.
//    - rvalid is honoured only in WAIT; rvalid in the gnt cycle or in IDLE/REQ is ignored.
//  Latency: ALU op 1 cycle. Store 1+g cycles (g = cycles to gnt, >=1). Load 1+g+r cycles (r >= 1).
//  ex_ready = (state==IDLE).
//   - A new instruction may be accepted in the same cycle the previous access retires to IDLE
//     (wb_valid of the old op and acceptance of the new one overlap).
//  Timeout:
//   - Counter cleared on entry to REQ and on REQ->WAIT; increments each cycle in REQ/WAIT.
//   - On reaching TIMEOUT_CYCLES-1 without the awaited event: abort to IDLE; bus_err pulse;
//     wb_valid=1 with rf_en forced 0.
//   - A gnt/rvalid arriving in the same cycle as the timeout wins (normal completion, no bus_err).
//  wb_out is held between wb_valid pulses; it is not cleared.
//  Reset mid-access: immediate return to IDLE; dmem_req drops asynchronously; a late rvalid after reset is ignored.
//  br_taken is not consumed here.
// STRUCTURE
//  mem_stage_pkg:
//   - mem_stage_out_t
//   - enum mem_state_t {IDLE, REQ, WAIT}
//   - WB_ALU=2'b00, WB_MEM=2'b01 (shared with decode)
//  Sub-module lsu_timeout_ctr:
//   - Parameterised by TIMEOUT_CYCLES.
//   - Inputs: clr, en. Output: expired.
//   - Counter width $clog2(TIMEOUT_CYCLES).
// TESTING
//  1. ALU op opr_res=32'h1234, rd=5, rf_en=1 -> next cycle wb_valid=1, wb_data=32'h1234, rd=5; dmem_req never asserted.
//  2. Load addr 32'h100, gnt after 2 cycles, rvalid 3 cycles later with rdata=32'hDEADBEEF
//     -> ex_ready low throughout; wb_valid once with wb_data=32'hDEADBEEF; total latency 6.
//  3. Store addr 32'h200, opr_b=32'hA5A5A5A5, gnt on first REQ cycle
//     -> dmem_we=1, dmem_wdata=32'hA5A5A5A5; wb_valid next cycle; no WAIT visit.
//  4. Load with opr_res=32'h103 -> misalign pulse; no dmem_req; wb_valid with rf_en=0.
//  5. Load granted, rvalid never returns, TIMEOUT_CYCLES=16 -> bus_err pulse after 16 WAIT cycles;
//     back to IDLE; ex_ready=1; later rvalid ignored.
//  6. Assert rst while in REQ -> dmem_req=0 immediately; all outputs 0; next ALU op processes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: EX input bundle, WB output bundle,
// writeback-select codes and FSM state encoding.
`timescale 1ns/1ps
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT
  } mem_state_t;

  // Mirrors the EX-stage result bundle layout.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] opr_b;
    logic [31:0] opr_res;
    logic        rf_en;
    logic        dm_en;
    logic [1:0]  wb_sel;
    logic        br_taken;
  } ex_stage_out_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rf_en;
    logic [31:0] wb_data;
    logic [1:0]  wb_sel;
  } mem_stage_out_t;

  function automatic logic is_mem_op(ex_stage_out_t ex);
    return ex.dm_en || (ex.wb_sel == WB_MEM);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/gnt/rvalid bus between the memory stage and data memory.
`timescale 1ns/1ps
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_timeout_ctr.sv
// Cycle counter bounding time spent waiting on the data bus.
`timescale 1ns/1ps
module lsu_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues word loads/stores, stalls EX while an access is
// outstanding, and registers the writeback bundle for WB.
`timescale 1ns/1ps
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  ex_stage_out_t  ex_in,
  input  logic           ex_valid,
  output logic           ex_ready,
  mem_stage_if.master    dmem,
  output mem_stage_out_t wb_out,
  output logic           wb_valid,
  output logic           misalign,
  output logic           bus_err
);

  mem_state_t     state_q, state_d;
  logic [4:0]     rd_q, rd_d;
  logic           rf_en_q, rf_en_d;
  logic [1:0]     wb_sel_q, wb_sel_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  mem_stage_out_t wb_q, wb_d;
  logic           wb_valid_q, wb_valid_d;
  logic           misalign_q, misalign_d;
  logic           bus_err_q, bus_err_d;

  logic        ctr_clr, ctr_en, expired;
  logic        retire, abort;
  logic [31:0] retire_data;
  logic        unused_br;

  assign unused_br = ex_in.br_taken;

  lsu_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    rf_en_d     = rf_en_q;
    wb_sel_d    = wb_sel_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wb_d        = wb_q;
    wb_valid_d  = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;
    retire      = 1'b0;
    abort       = 1'b0;
    retire_data = '0;

    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem_op(ex_in)) begin
            wb_valid_d    = 1'b1;
            wb_d.rd       = ex_in.rd;
            wb_d.rf_en    = ex_in.rf_en;
            wb_d.wb_data  = ex_in.opr_res;
            wb_d.wb_sel   = ex_in.wb_sel;
          end else if (ex_in.opr_res[1:0] != 2'b00) begin
            misalign_d    = 1'b1;
            wb_valid_d    = 1'b1;
            wb_d.rd       = ex_in.rd;
            wb_d.rf_en    = 1'b0;
            wb_d.wb_data  = ex_in.opr_res;
            wb_d.wb_sel   = ex_in.wb_sel;
          end else begin
            rd_d     = ex_in.rd;
            rf_en_d  = ex_in.rf_en;
            wb_sel_d = ex_in.wb_sel;
            we_d     = ex_in.dm_en;
            addr_d   = {ex_in.opr_res[31:2], 2'b00};
            wdata_d  = ex_in.opr_b;
            ctr_clr  = 1'b1;
            state_d  = REQ;
          end
        end
      end
      // A grant or rvalid in the expiry cycle takes priority over the abort.
      REQ: begin
        ctr_en = 1'b1;
        if (dmem.gnt) begin
          if (we_q) begin
            retire      = 1'b1;
            retire_data = addr_q;
          end else begin
            ctr_clr = 1'b1;
            state_d = WAIT;
          end
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      WAIT: begin
        ctr_en = 1'b1;
        if (dmem.rvalid) begin
          retire      = 1'b1;
          retire_data = dmem.rdata;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire || abort) begin
      state_d      = IDLE;
      wb_valid_d   = 1'b1;
      bus_err_d    = abort;
      wb_d.rd      = rd_q;
      wb_d.rf_en   = rf_en_q && !abort;
      wb_d.wb_data = retire_data;
      wb_d.wb_sel  = wb_sel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      rf_en_q    <= 1'b0;
      wb_sel_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      rf_en_q    <= rf_en_d;
      wb_sel_q   <= wb_sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign ex_ready   = (state_q == IDLE);
  assign dmem.req   = (state_q == REQ);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign wb_out     = wb_q;
  assign wb_valid   = wb_valid_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instructions checked against a latency/outcome model of the stage.
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst;
  ex_stage_out_t  ex_in;
  logic           ex_valid, ex_ready;
  mem_stage_out_t wb_out;
  logic           wb_valid, misalign, bus_err;
  int             checks = 0;
  int             failures = 0;

  mem_stage_if dmem();

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .ex_in(ex_in), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .dmem(dmem), .wb_out(wb_out), .wb_valid(wb_valid), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int             lat;
    mem_stage_out_t wb;
    int             nvalid;
    int             req_cyc;
    int             ready_bad;
    bit             mis;
    bit             berr;
    logic [31:0]    addr;
    bit             we;
    logic [31:0]    wdata;
    bit             stable;
  } obs_t;

  typedef struct packed {
    int          lat;
    bit          mis;
    bit          berr;
    bit          rf;
    bit          chk;
    logic [31:0] data;
    int          req;
  } exp_t;

  function automatic ex_stage_out_t mk(input logic [4:0] rd, input logic rf_en, input logic dm_en,
                                       input logic [1:0] sel, input logic [31:0] res, input logic [31:0] b);
    ex_stage_out_t e;
    e.rd = rd; e.rf_en = rf_en; e.dm_en = dm_en; e.wb_sel = sel;
    e.opr_res = res; e.opr_b = b; e.br_taken = 1'($urandom);
    return e;
  endfunction

  // Outcome predicted from the stage's rules: g = REQ cycle of gnt, r = WAIT cycle of rvalid (0 = never).
  function automatic exp_t model(input ex_stage_out_t i, input int g, input int r, input logic [31:0] rdv);
    exp_t e;
    bit mem_op;
    e = '0;
    mem_op = i.dm_en || (i.wb_sel == WB_MEM);
    if (!mem_op) begin
      e.lat = 1; e.rf = i.rf_en; e.chk = 1; e.data = i.opr_res;
    end else if (i.opr_res[1:0] != 2'b00) begin
      e.lat = 1; e.mis = 1;
    end else if (g == 0 || g > T) begin
      e.lat = 1 + T; e.berr = 1; e.req = T;
    end else if (i.dm_en) begin
      e.lat = 1 + g; e.rf = i.rf_en; e.req = g;
    end else if (r == 0 || r > T) begin
      e.lat = 1 + g + T; e.berr = 1; e.req = g;
    end else begin
      e.lat = 1 + g + r; e.rf = i.rf_en; e.chk = 1; e.data = rdv; e.req = g;
    end
    return e;
  endfunction

  // Presents one instruction, acts as the memory, and records what the stage did.
  task automatic do_op(input ex_stage_out_t ins, input int g, input int r, input bit rv_in_gnt,
                       input logic [31:0] rdv, output obs_t o);
    int req_cnt = 0, wcnt = 0;
    bit gnted = 0;
    o = '0; o.lat = -1; o.stable = 1;
    @(negedge clk); ex_in = ins; ex_valid = 1'b1;
    @(posedge clk); #1; ex_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (wb_valid) begin
        o.nvalid++;
        if (o.lat < 0) begin o.lat = k; o.wb = wb_out; end
      end
      if (misalign) o.mis = 1;
      if (bus_err) o.berr = 1;
      if (o.lat < 0 && ex_ready) o.ready_bad++;
      if (dmem.req) begin
        if (o.req_cyc == 0) begin o.addr = dmem.addr; o.we = dmem.we; o.wdata = dmem.wdata; end
        else if (dmem.addr !== o.addr || dmem.we !== o.we || dmem.wdata !== o.wdata) o.stable = 0;
        o.req_cyc++;
      end
      if (o.lat > 0 && k >= o.lat + 2) break;
      @(negedge clk);
      dmem.rdata = $urandom;
      if (gnted) begin
        wcnt++;
        if (wcnt == r) begin dmem.rvalid = 1'b1; dmem.rdata = rdv; end
      end
      if (dmem.req) begin
        req_cnt++;
        if (req_cnt == g) begin
          dmem.gnt = 1'b1; gnted = 1;
          if (rv_in_gnt) begin dmem.rvalid = 1'b1; dmem.rdata = ~rdv; end
        end
      end
      @(posedge clk); #1; dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_in = '0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({dmem.req, wb_valid, misalign, bus_err} !== 4'b0) begin
      failures++; $display("FAIL reset_pulses got=%b want=0000", {dmem.req, wb_valid, misalign, bus_err}); end
    checks++; if (wb_out !== '0) begin failures++; $display("FAIL reset_wb_out got=%h want=0", wb_out); end
    checks++; if ({dmem.we, dmem.addr, dmem.wdata} !== '0) begin
      failures++; $display("FAIL reset_bus got=%h want=0", {dmem.we, dmem.addr, dmem.wdata}); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ex_ready); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_alu();
    obs_t o;
    do_op(mk(5'd5, 1'b1, 1'b0, WB_ALU, 32'h1234, 32'h0), 0, 0, 0, 32'h0, o);
    checks++; if (o.lat !== 1) begin failures++; $display("FAIL alu_latency got=%0d want=1", o.lat); end
    checks++; if (o.wb.wb_data !== 32'h1234 || o.wb.rd !== 5'd5 || o.wb.rf_en !== 1'b1) begin
      failures++; $display("FAIL alu_wb got=%h want=rd5 rf1 data1234", o.wb); end
    checks++; if (o.req_cyc !== 0 || o.nvalid !== 1) begin
      failures++; $display("FAIL alu_req_valid got req=%0d nv=%0d want 0/1", o.req_cyc, o.nvalid); end
  endtask

  task automatic test_load();
    obs_t o;
    do_op(mk(5'd9, 1'b1, 1'b0, WB_MEM, 32'h100, 32'h0), 2, 3, 0, 32'hDEADBEEF, o);
    checks++; if (o.lat !== 6) begin failures++; $display("FAIL load_latency got=%0d want=6", o.lat); end
    checks++; if (o.wb.wb_data !== 32'hDEADBEEF || o.wb.rd !== 5'd9) begin
      failures++; $display("FAIL load_data got=%h want=DEADBEEF rd9", o.wb); end
    checks++; if (o.ready_bad !== 0 || o.nvalid !== 1) begin
      failures++; $display("FAIL load_stall got ready_hi=%0d nv=%0d want 0/1", o.ready_bad, o.nvalid); end
    checks++; if (o.addr !== 32'h100 || o.we !== 1'b0 || !o.stable) begin
      failures++; $display("FAIL load_bus got addr=%h we=%b st=%b want 100/0/1", o.addr, o.we, o.stable); end
  endtask

  task automatic test_store();
    obs_t o;
    do_op(mk(5'd3, 1'b0, 1'b1, WB_ALU, 32'h200, 32'hA5A5A5A5), 1, 0, 0, 32'h0, o);
    checks++; if (o.we !== 1'b1 || o.wdata !== 32'hA5A5A5A5 || o.addr !== 32'h200) begin
      failures++; $display("FAIL store_bus got we=%b wd=%h a=%h want 1/A5A5A5A5/200", o.we, o.wdata, o.addr); end
    checks++; if (o.lat !== 2 || o.req_cyc !== 1 || o.nvalid !== 1) begin
      failures++; $display("FAIL store_timing got lat=%0d req=%0d nv=%0d want 2/1/1", o.lat, o.req_cyc, o.nvalid); end
  endtask

  task automatic test_misalign();
    obs_t o;
    do_op(mk(5'd7, 1'b1, 1'b0, WB_MEM, 32'h103, 32'h0), 1, 1, 0, 32'h0, o);
    checks++; if (o.mis !== 1'b1 || o.req_cyc !== 0) begin
      failures++; $display("FAIL misalign_pulse got mis=%b req=%0d want 1/0", o.mis, o.req_cyc); end
    checks++; if (o.lat !== 1 || o.wb.rf_en !== 1'b0 || o.nvalid !== 1) begin
      failures++; $display("FAIL misalign_wb got lat=%0d rf=%b nv=%0d want 1/0/1", o.lat, o.wb.rf_en, o.nvalid); end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_op(mk(5'd11, 1'b1, 1'b0, WB_MEM, 32'h300, 32'h0), 1, 0, 0, 32'h0, o);
    checks++; if (o.berr !== 1'b1 || o.lat !== 2 + T) begin
      failures++; $display("FAIL timeout_berr got berr=%b lat=%0d want 1/%0d", o.berr, o.lat, 2 + T); end
    checks++; if (o.wb.rf_en !== 1'b0 || ex_ready !== 1'b1) begin
      failures++; $display("FAIL timeout_state got rf=%b ready=%b want 0/1", o.wb.rf_en, ex_ready); end
    @(negedge clk); dmem.rvalid = 1'b1; dmem.rdata = 32'h5555AAAA;
    @(posedge clk); #1; dmem.rvalid = 1'b0;
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL timeout_late_rvalid got wbv=%b berr=%b want 0/0", wb_valid, bus_err); end
  endtask

  task automatic test_boundary();
    obs_t o;
    do_op(mk(5'd1, 1'b1, 1'b1, WB_ALU, 32'h400, 32'h1), T, 0, 0, 32'h0, o);
    checks++; if (o.berr !== 1'b0 || o.lat !== 1 + T) begin
      failures++; $display("FAIL bound_gnt_last got berr=%b lat=%0d want 0/%0d", o.berr, o.lat, 1 + T); end
    do_op(mk(5'd2, 1'b1, 1'b1, WB_ALU, 32'h404, 32'h2), 0, 0, 0, 32'h0, o);
    checks++; if (o.berr !== 1'b1 || o.lat !== 1 + T || o.req_cyc !== T) begin
      failures++; $display("FAIL bound_req_timeout got berr=%b lat=%0d req=%0d want 1/%0d/%0d", o.berr, o.lat, o.req_cyc, 1 + T, T); end
    do_op(mk(5'd4, 1'b1, 1'b0, WB_MEM, 32'h408, 32'h0), 1, T, 1, 32'hCAFEF00D, o);
    checks++; if (o.berr !== 1'b0 || o.lat !== 2 + T || o.wb.wb_data !== 32'hCAFEF00D) begin
      failures++; $display("FAIL bound_rvalid_last got berr=%b lat=%0d d=%h want 0/%0d/CAFEF00D", o.berr, o.lat, o.wb.wb_data, 2 + T); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); ex_in = mk(5'd6, 1'b0, 1'b1, WB_ALU, 32'h500, 32'h77); ex_valid = 1'b1;
    @(posedge clk); #1; ex_valid = 1'b0;
    @(negedge clk); dmem.gnt = 1'b1;
    @(posedge clk); #1; dmem.gnt = 1'b0;
    checks++; if (wb_valid !== 1'b1 || ex_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_retire got wbv=%b ready=%b want 1/1", wb_valid, ex_ready); end
    @(negedge clk); ex_in = mk(5'd8, 1'b1, 1'b0, WB_ALU, 32'h600D, 32'h0); ex_valid = 1'b1;
    @(posedge clk); #1; ex_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_out.wb_data !== 32'h600D || wb_out.rd !== 5'd8) begin
      failures++; $display("FAIL b2b_next got wbv=%b wb=%h want 1 rd8 600D", wb_valid, wb_out); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clk); ex_in = mk(5'd12, 1'b1, 1'b0, WB_MEM, 32'h700, 32'h0); ex_valid = 1'b1;
    @(posedge clk); #1; ex_valid = 1'b0;
    checks++; if (dmem.req !== 1'b1) begin failures++; $display("FAIL rstmid_inreq got=%b want=1", dmem.req); end
    #2; rst = 1'b1; #1;
    checks++; if (dmem.req !== 1'b0 || wb_valid !== 1'b0 || wb_out !== '0 || ex_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_async got req=%b wbv=%b wb=%h ready=%b want 0/0/0/1", dmem.req, wb_valid, wb_out, ex_ready); end
    @(negedge clk); dmem.rvalid = 1'b1; dmem.rdata = 32'h1111;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; dmem.rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rstmid_late_rvalid got=%b want=0", wb_valid); end
    do_op(mk(5'd13, 1'b1, 1'b0, WB_ALU, 32'h42, 32'h0), 0, 0, 0, 32'h0, o);
    checks++; if (o.lat !== 1 || o.wb.wb_data !== 32'h42 || o.wb.rd !== 5'd13) begin
      failures++; $display("FAIL rstmid_alu got lat=%0d wb=%h want 1 rd13 42", o.lat, o.wb); end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    ex_stage_out_t ins;
    int g, r, kind;
    logic [31:0] rdv, res;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      res  = $urandom;
      if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
      case (kind)
        0: ins = mk(5'($urandom), 1'($urandom), 1'b0, 2'($urandom_range(2, 3)), res, $urandom);
        1: ins = mk(5'($urandom), 1'($urandom), 1'b0, WB_ALU, res, $urandom);
        2: ins = mk(5'($urandom), 1'($urandom), 1'b1, 2'($urandom), res, $urandom);
        default: ins = mk(5'($urandom), 1'($urandom), 1'b0, WB_MEM, res, $urandom);
      endcase
      g = $urandom_range(0, 11); g = (g == 0) ? T : (g == 1) ? T + 1 : $urandom_range(1, 4);
      r = $urandom_range(0, 11); r = (r == 0) ? T : (r == 1) ? T + 1 : $urandom_range(1, 4);
      rdv = $urandom;
      e = model(ins, g, r, rdv);
      do_op(ins, g, r, 1'($urandom), rdv, o);
      checks++; if (o.lat !== e.lat || o.nvalid !== 1) begin
        failures++; $display("FAIL rnd%0d_timing got lat=%0d nv=%0d want %0d/1", n, o.lat, o.nvalid, e.lat); end
      checks++; if (o.wb.rd !== ins.rd || o.wb.rf_en !== e.rf || o.wb.wb_sel !== ins.wb_sel) begin
        failures++; $display("FAIL rnd%0d_wbctl got rd=%0d rf=%b sel=%0d want %0d/%b/%0d", n, o.wb.rd, o.wb.rf_en, o.wb.wb_sel, ins.rd, e.rf, ins.wb_sel); end
      if (e.chk) begin
        checks++; if (o.wb.wb_data !== e.data) begin
          failures++; $display("FAIL rnd%0d_data got=%h want=%h", n, o.wb.wb_data, e.data); end
      end
      checks++; if (o.mis !== e.mis || o.berr !== e.berr || o.ready_bad !== 0) begin
        failures++; $display("FAIL rnd%0d_flags got mis=%b berr=%b rdyhi=%0d want %b/%b/0", n, o.mis, o.berr, o.ready_bad, e.mis, e.berr); end
      checks++; if (o.req_cyc !== e.req) begin
        failures++; $display("FAIL rnd%0d_reqcyc got=%0d want=%0d", n, o.req_cyc, e.req); end
      if (e.req > 0) begin
        checks++; if (o.addr !== {ins.opr_res[31:2], 2'b00} || o.we !== ins.dm_en ||
                      o.wdata !== ins.opr_b || !o.stable) begin
          failures++; $display("FAIL rnd%0d_bus got a=%h we=%b wd=%h st=%b want %h/%b/%h/1", n,
                               o.addr, o.we, o.wdata, o.stable, {ins.opr_res[31:2], 2'b00}, ins.dm_en, ins.opr_b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog elapsed=%0t limit=1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
